// File: rtl/fft_coproc.sv
// Iterative radix-2 DIT FFT/IFFT coprocessor: one butterfly per clock over an in-place
// complex buffer. Samples load bit-reversed so results read back in natural order.
module fft_coproc #(
  parameter int N_POINTS = 8,
  parameter int DATA_W   = 32,
  parameter int FRAC_W   = 8
) (
  input  logic                        clk,
  input  logic                        rst_n,
  input  logic                        wr_en,
  input  logic [$clog2(N_POINTS)-1:0] wr_idx,
  input  logic [DATA_W-1:0]           wr_real,
  input  logic [DATA_W-1:0]           wr_imag,
  input  logic                        start,
  input  logic                        inverse,
  output logic                        busy,
  output logic                        done,
  input  logic [$clog2(N_POINTS)-1:0] rd_idx,
  output logic [DATA_W-1:0]           rd_real,
  output logic [DATA_W-1:0]           rd_imag
);

  localparam int L      = $clog2(N_POINTS);
  localparam int HALF_N = N_POINTS / 2;
  localparam int BW     = L - 1;
  localparam int SW     = $clog2(L);
  localparam int TW_W   = FRAC_W + 2;
  localparam int PW     = 2 * DATA_W;
  localparam real SCALE = 1.0 * (1 << FRAC_W);

  // Handshake: wr_en and start are single-cycle strobes, accepted on any rising edge
  // where busy=0 and silently dropped while busy=1; done is a level that stays high
  // until the next accepted wr_en or start.
  typedef enum logic [1:0] {S_IDLE, S_RUN, S_DONE} state_t;
  state_t state, state_nxt;

  logic signed [DATA_W-1:0] buf_re [N_POINTS];
  logic signed [DATA_W-1:0] buf_im [N_POINTS];
  logic signed [TW_W-1:0]   tw_re  [HALF_N];
  logic signed [TW_W-1:0]   tw_im  [HALF_N];
  logic [SW-1:0]            stage;
  logic [BW-1:0]            bfly;
  logic                     inv_q;

  // Twiddle table W^k = round(2^FRAC_W * exp(-j*2*pi*k/N)), fixed at elaboration.
  for (genvar k = 0; k < HALF_N; k++) begin : g_tw
    localparam real ANG = 6.283185307179586 * k / N_POINTS;
    localparam real CR  = $cos(ANG) * SCALE;
    localparam real CI  = -$sin(ANG) * SCALE;
    localparam int  CRI = (CR >= 0.0) ? $rtoi(CR + 0.5) : -$rtoi(0.5 - CR);
    localparam int  CII = (CI >= 0.0) ? $rtoi(CI + 0.5) : -$rtoi(0.5 - CI);
    assign tw_re[k] = TW_W'(CRI);
    assign tw_im[k] = TW_W'(CII);
  end

  function automatic logic [L-1:0] bitrev(input logic [L-1:0] x);
    logic [L-1:0] r;
    for (int i = 0; i < L; i++) r[i] = x[L-1-i];
    return r;
  endfunction

  logic accept_wr, accept_start, last_bfly, last_stage;
  assign accept_wr    = wr_en && (state != S_RUN);
  assign accept_start = start && (state != S_RUN);
  assign last_stage   = (stage == SW'(L - 1));
  assign last_bfly    = (state == S_RUN) && last_stage && (bfly == {BW{1'b1}});
  assign busy         = (state == S_RUN);
  assign done         = (state == S_DONE);

  always_comb begin
    state_nxt = state;
    case (state)
      S_IDLE:  if (accept_start) state_nxt = S_RUN;
      S_RUN:   if (last_bfly) state_nxt = S_DONE;
      S_DONE:  if (start) state_nxt = S_RUN;
               else if (wr_en) state_nxt = S_IDLE;
      default: state_nxt = S_IDLE;
    endcase
  end

  // Butterfly datapath for the current (stage, bfly) pair.
  int                       s_i;
  logic [L-1:0]             b_ext, mask, top_idx, bot_idx;
  logic [BW-1:0]            tw_sel;
  logic signed [TW_W-1:0]   w_re, w_im;
  logic signed [PW-1:0]     br_x, bi_x, wr_x, wi_x, pr_full, pi_full;
  logic signed [DATA_W-1:0] p_re, p_im, sum_re, sum_im, dif_re, dif_im;
  logic signed [DATA_W-1:0] top_re, top_im, bot_re, bot_im;

  always_comb begin
    s_i     = int'(stage);
    b_ext   = L'(bfly);
    mask    = L'((1 << s_i) - 1);
    top_idx = ((b_ext >> s_i) << (s_i + 1)) | (b_ext & mask);
    bot_idx = top_idx | L'(1 << s_i);
    tw_sel  = BW'((b_ext & mask) << (L - 1 - s_i));
    w_re    = tw_re[tw_sel];
    w_im    = inv_q ? -tw_im[tw_sel] : tw_im[tw_sel];
    br_x    = PW'(buf_re[bot_idx]);
    bi_x    = PW'(buf_im[bot_idx]);
    wr_x    = PW'(w_re);
    wi_x    = PW'(w_im);
    pr_full = ((br_x * wr_x) - (bi_x * wi_x)) >>> FRAC_W;
    pi_full = ((br_x * wi_x) + (bi_x * wr_x)) >>> FRAC_W;
    p_re    = DATA_W'(pr_full);
    p_im    = DATA_W'(pi_full);
    sum_re  = buf_re[top_idx] + p_re;
    sum_im  = buf_im[top_idx] + p_im;
    dif_re  = buf_re[top_idx] - p_re;
    dif_im  = buf_im[top_idx] - p_im;
    // Inverse divides by N on the final stage only.
    if (inv_q && last_stage) begin
      top_re = sum_re >>> L;
      top_im = sum_im >>> L;
      bot_re = dif_re >>> L;
      bot_im = dif_im >>> L;
    end else begin
      top_re = sum_re;
      top_im = sum_im;
      bot_re = dif_re;
      bot_im = dif_im;
    end
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state   <= S_IDLE;
      stage   <= '0;
      bfly    <= '0;
      inv_q   <= 1'b0;
      rd_real <= '0;
      rd_imag <= '0;
      for (int i = 0; i < N_POINTS; i++) begin
        buf_re[i] <= '0;
        buf_im[i] <= '0;
      end
    end else begin
      state <= state_nxt;
      if (accept_start) begin
        inv_q <= inverse;
        stage <= '0;
        bfly  <= '0;
      end else if (state == S_RUN) begin
        if (bfly == {BW{1'b1}}) begin
          bfly  <= '0;
          stage <= last_stage ? '0 : stage + SW'(1);
        end else begin
          bfly <= bfly + BW'(1);
        end
      end
      if (accept_wr) begin
        buf_re[bitrev(wr_idx)] <= wr_real;
        buf_im[bitrev(wr_idx)] <= wr_imag;
      end
      if (state == S_RUN) begin
        buf_re[top_idx] <= top_re;
        buf_im[top_idx] <= top_im;
        buf_re[bot_idx] <= bot_re;
        buf_im[bot_idx] <= bot_im;
      end
      rd_real <= (state == S_RUN) ? '0 : buf_re[rd_idx];
      rd_imag <= (state == S_RUN) ? '0 : buf_im[rd_idx];
    end
  end

endmodule

// File: tb/tb_fft_coproc.sv
// Directed bench for fft_coproc: 8-point transforms with hand-computed spectra,
// protocol/reset corner cases, and a 16-point latency run on a second instance.
module tb_fft_coproc;

  logic clk = 1'b0;
  logic rst_n = 1'b0;

  logic               wr_en = 0, start = 0, inverse = 0;
  logic [2:0]         wr_idx = 0, rd_idx = 0;
  logic signed [31:0] wr_real = 0, wr_imag = 0, rd_real, rd_imag;
  logic               busy, done;

  logic               s_wr_en = 0, s_start = 0;
  logic [3:0]         s_wr_idx = 0, s_rd_idx = 0;
  logic signed [31:0] s_wr_real = 0, s_wr_imag = 0, s_rd_real, s_rd_imag;
  logic               s_busy, s_done;

  int total = 0;
  int bad = 0;

  logic signed [31:0] exp_re_q[$];
  logic signed [31:0] exp_im_q[$];
  logic signed [31:0] vec_re[8];
  logic signed [31:0] vec_im[8];

  fft_coproc #(.N_POINTS(8), .DATA_W(32), .FRAC_W(8)) dut (
    .clk(clk), .rst_n(rst_n), .wr_en(wr_en), .wr_idx(wr_idx),
    .wr_real(wr_real), .wr_imag(wr_imag), .start(start), .inverse(inverse),
    .busy(busy), .done(done), .rd_idx(rd_idx), .rd_real(rd_real), .rd_imag(rd_imag)
  );

  fft_coproc #(.N_POINTS(16), .DATA_W(32), .FRAC_W(8)) dut16 (
    .clk(clk), .rst_n(rst_n), .wr_en(s_wr_en), .wr_idx(s_wr_idx),
    .wr_real(s_wr_real), .wr_imag(s_wr_imag), .start(s_start), .inverse(1'b0),
    .busy(s_busy), .done(s_done), .rd_idx(s_rd_idx), .rd_real(s_rd_real), .rd_imag(s_rd_imag)
  );

  // clock / reset
  always #5 clk = ~clk;

  task automatic chk(input string tag, input longint got, input longint exp);
    total++;
    if (got != exp) begin
      bad++;
      $display("FAIL %s: got %0d, want %0d", tag, got, exp);
    end
  endtask

  // driver tasks: all inputs change 1 time unit after a rising edge
  task automatic load8();
    for (int i = 0; i < 8; i++) begin
      wr_en = 1; wr_idx = 3'(i); wr_real = vec_re[i]; wr_imag = vec_im[i];
      @(posedge clk); #1;
    end
    wr_en = 0;
  endtask

  task automatic run8(input string tag, input logic inv, input bit inject);
    int cyc, bcnt;
    start = 1; inverse = inv;
    @(posedge clk); #1;
    start = 0; inverse = 0;
    cyc = 1; bcnt = 0;
    while (!done && cyc < 200) begin
      if (busy) bcnt++;
      if (inject) begin
        start = (cyc == 3); inverse = (cyc == 3);
        wr_en = (cyc == 6); wr_idx = 3'd3; wr_real = 999; wr_imag = -5;
        if (cyc == 6) chk({tag, "_rd_busy"}, rd_real, 0);
      end
      @(posedge clk); #1;
      cyc++;
    end
    start = 0; wr_en = 0; inverse = 0;
    chk({tag, "_latency"}, cyc, 13);
    chk({tag, "_busy_cycles"}, bcnt, 12);
  endtask

  // scoreboard: compare all 8 results against the expected queues
  task automatic read8(input string tag);
    logic signed [31:0] er, ei;
    for (int k = 0; k < 8; k++) begin
      rd_idx = 3'(k);
      @(posedge clk); #1;
      er = exp_re_q.pop_front();
      ei = exp_im_q.pop_front();
      chk($sformatf("%s_re[%0d]", tag, k), rd_real, er);
      chk($sformatf("%s_im[%0d]", tag, k), rd_imag, ei);
    end
  endtask

  task automatic push_exp(input logic signed [31:0] re, input logic signed [31:0] im);
    exp_re_q.push_back(re);
    exp_im_q.push_back(im);
  endtask

  initial begin
    int cyc, bcnt;

    repeat (2) @(posedge clk);
    #1;
    chk("rst_busy", busy, 0);
    chk("rst_done", done, 0);
    chk("rst_rd_real", rd_real, 0);
    chk("rst_rd_imag", rd_imag, 0);
    rst_n = 1;

    // impulse at n=0 -> flat spectrum
    vec_re = '{256, 0, 0, 0, 0, 0, 0, 0};
    vec_im = '{0, 0, 0, 0, 0, 0, 0, 0};
    load8();
    run8("impulse", 1'b0, 1'b0);
    for (int k = 0; k < 8; k++) push_exp(256, 0);
    read8("impulse");
    chk("done_held", done, 1);

    // impulse at n=1 -> X[k] = 256*W8^k
    vec_re = '{0, 256, 0, 0, 0, 0, 0, 0};
    wr_en = 1; wr_idx = 0; wr_real = 0; wr_imag = 0;
    @(posedge clk); #1;
    wr_en = 0;
    chk("wr_clears_done", done, 0);
    load8();
    run8("shift", 1'b0, 1'b0);
    push_exp(256, 0);   push_exp(181, -181); push_exp(0, -256); push_exp(-181, -181);
    push_exp(-256, 0);  push_exp(-181, 181); push_exp(0, 256);  push_exp(181, 181);
    read8("shift");

    // DC, then inverse in place
    vec_re = '{100, 100, 100, 100, 100, 100, 100, 100};
    load8();
    run8("dc", 1'b0, 1'b0);
    push_exp(800, 0);
    for (int k = 1; k < 8; k++) push_exp(0, 0);
    read8("dc");
    run8("dc_inv", 1'b1, 1'b0);
    for (int k = 0; k < 8; k++) push_exp(100, 0);
    read8("dc_inv");

    // inverse of a flat spectrum -> impulse
    vec_re = '{256, 256, 256, 256, 256, 256, 256, 256};
    load8();
    run8("ifft", 1'b1, 1'b0);
    push_exp(256, 0);
    for (int k = 1; k < 8; k++) push_exp(0, 0);
    read8("ifft");

    // start/write during a run must be ignored
    vec_re = '{256, 0, 0, 0, 0, 0, 0, 0};
    load8();
    rd_idx = 0;
    run8("proto", 1'b0, 1'b1);
    for (int k = 0; k < 8; k++) push_exp(256, 0);
    read8("proto");

    // reset in the middle of a run
    load8();
    start = 1;
    @(posedge clk); #1;
    start = 0;
    repeat (4) begin @(posedge clk); #1; end
    chk("midrun_busy_before", busy, 1);
    rst_n = 0;
    @(posedge clk); #1;
    rst_n = 1;
    chk("midrst_busy", busy, 0);
    chk("midrst_done", done, 0);
    chk("midrst_rd_real", rd_real, 0);
    for (int k = 0; k < 8; k++) push_exp(0, 0);
    read8("midrst");

    // 16-point impulse
    s_wr_en = 1; s_wr_idx = 0; s_wr_real = 256; s_wr_imag = 0;
    @(posedge clk); #1;
    s_wr_en = 0;
    s_start = 1;
    @(posedge clk); #1;
    s_start = 0;
    cyc = 1; bcnt = 0;
    while (!s_done && cyc < 200) begin
      if (s_busy) bcnt++;
      @(posedge clk); #1;
      cyc++;
    end
    chk("n16_latency", cyc, 33);
    chk("n16_busy_cycles", bcnt, 32);
    for (int k = 0; k < 16; k++) begin
      s_rd_idx = 4'(k);
      @(posedge clk); #1;
      chk($sformatf("n16_re[%0d]", k), s_rd_real, 256);
      chk($sformatf("n16_im[%0d]", k), s_rd_imag, 0);
    end

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
